vga_frame_update_scheduler: RTL and testbench

//  Sits between game logic and the VGA interface; owns the mario/goomba positions and 12x17 background tile map driven into it.

---
 rtl/vga_frame_update_scheduler.sv | 185 ++++++++++++++++++
 tb/tb_vga_frame_update_scheduler.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_frame_update_scheduler.sv
// Double-buffered sprite/tile state for the VGA path: writers fill a shadow copy
// during a vblank update window, and the shadow is committed atomically at window close.
module vga_frame_update_scheduler #(
  parameter logic [7:0] SKY           = 8'd1,
  parameter bit         VSYNC_POL     = 1'b0,
  parameter int         WINDOW_CYCLES = 1000,
  parameter int         ROWS          = 12,
  parameter int         COLS          = 17
) (
  input  logic                             vga_clock,
  input  logic                             reset,
  input  logic                             vsync,
  input  logic [1:0]                       req,
  output logic [1:0]                       grant,
  input  logic                             tile_we,
  input  logic [3:0]                       tile_row,
  input  logic [4:0]                       tile_col,
  input  logic [7:0]                       tile_data,
  input  logic                             pos_we,
  input  logic                             pos_sel,
  input  logic signed [31:0]               pos_x,
  input  logic signed [31:0]               pos_y,
  output logic signed [31:0]               mario_x,
  output logic signed [31:0]               mario_y,
  output logic signed [31:0]               goomba_x,
  output logic signed [31:0]               goomba_y,
  output logic [ROWS-1:0][COLS-1:0][7:0]   background,
  output logic [15:0]                      frame_count,
  output logic                             commit,
  output logic                             overrun,
  output logic                             bad_addr,
  output logic [1:0]                       fsm_state
);

  localparam int CW = $clog2(WINDOW_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(WINDOW_CYCLES - 1);

  typedef enum logic [1:0] {
    S_ACTIVE = 2'd0,
    S_WINDOW = 2'd1,
    S_COMMIT = 2'd2
  } state_t;

  typedef logic [ROWS-1:0][COLS-1:0][7:0] tiles_t;

  state_t             state_q;
  logic [1:0]         rst_pipe_q;
  logic               rst_n_sync;
  logic               vsync_q, vsync_prev_q;
  logic               vsync_edge;
  logic [CW-1:0]      cnt_q;
  logic [1:0]         grant_q;
  logic               rr_q;
  logic [15:0]        frame_count_q;
  logic               commit_q, overrun_q, bad_addr_q;

  tiles_t             sh_tiles_q, sh_tiles_d, live_tiles_q;
  logic signed [31:0] sh_mx_q, sh_my_q, sh_gx_q, sh_gy_q;
  logic signed [31:0] sh_mx_d, sh_my_d, sh_gx_d, sh_gy_d;
  logic signed [31:0] mx_q, my_q, gx_q, gy_q;
  logic               bad_addr_set;

  // Reset asserts asynchronously but leaves reset two clock edges after release.
  always_ff @(posedge vga_clock or negedge reset) begin
    if (!reset) rst_pipe_q <= 2'b00;
    else        rst_pipe_q <= {rst_pipe_q[0], 1'b1};
  end
  assign rst_n_sync = rst_pipe_q[1];

  assign vsync_edge = (vsync_q == VSYNC_POL) && (vsync_prev_q != VSYNC_POL);

  // Handshake: a writer holds req high; once grant shows its bit it may strobe
  // tile_we/pos_we on any cycle grant is still set. Dropping req releases grant.
  always_comb begin
    sh_tiles_d   = sh_tiles_q;
    sh_mx_d      = sh_mx_q;
    sh_my_d      = sh_my_q;
    sh_gx_d      = sh_gx_q;
    sh_gy_d      = sh_gy_q;
    bad_addr_set = 1'b0;
    if (state_q == S_WINDOW && grant_q != 2'b00) begin
      if (tile_we) begin
        if (int'(tile_row) < ROWS && int'(tile_col) < COLS)
          sh_tiles_d[tile_row][tile_col] = tile_data;
        else
          bad_addr_set = 1'b1;
      end
      if (pos_we) begin
        if (pos_sel) begin
          sh_gx_d = pos_x;
          sh_gy_d = pos_y;
        end else begin
          sh_mx_d = pos_x;
          sh_my_d = pos_y;
        end
      end
    end
  end

  always_ff @(posedge vga_clock or negedge rst_n_sync) begin
    if (!rst_n_sync) begin
      state_q       <= S_ACTIVE;
      vsync_q       <= ~VSYNC_POL;
      vsync_prev_q  <= ~VSYNC_POL;
      cnt_q         <= '0;
      grant_q       <= 2'b00;
      rr_q          <= 1'b0;
      frame_count_q <= 16'd0;
      commit_q      <= 1'b0;
      overrun_q     <= 1'b0;
      bad_addr_q    <= 1'b0;
      for (int r = 0; r < ROWS; r++)
        for (int c = 0; c < COLS; c++) begin
          sh_tiles_q[r][c]   <= SKY;
          live_tiles_q[r][c] <= SKY;
        end
      sh_mx_q <= '0; sh_my_q <= '0; sh_gx_q <= '0; sh_gy_q <= '0;
      mx_q    <= '0; my_q    <= '0; gx_q    <= '0; gy_q    <= '0;
    end else begin
      vsync_q      <= vsync;
      vsync_prev_q <= vsync_q;
      commit_q     <= 1'b0;
      sh_tiles_q   <= sh_tiles_d;
      sh_mx_q      <= sh_mx_d;
      sh_my_q      <= sh_my_d;
      sh_gx_q      <= sh_gx_d;
      sh_gy_q      <= sh_gy_d;
      if (bad_addr_set) bad_addr_q <= 1'b1;
      case (state_q)
        S_ACTIVE: begin
          if (vsync_edge) begin
            state_q <= S_WINDOW;
            cnt_q   <= '0;
          end
        end
        S_WINDOW: begin
          if (cnt_q == LAST) begin
            // Live copy takes the next-shadow so a write in the final cycle is kept.
            state_q       <= S_COMMIT;
            grant_q       <= 2'b00;
            if (|req) overrun_q <= 1'b1;
            live_tiles_q  <= sh_tiles_d;
            mx_q          <= sh_mx_d;
            my_q          <= sh_my_d;
            gx_q          <= sh_gx_d;
            gy_q          <= sh_gy_d;
            commit_q      <= 1'b1;
            frame_count_q <= frame_count_q + 16'd1;
          end else begin
            cnt_q <= cnt_q + CW'(1);
            if (grant_q == 2'b00) begin
              if (req == 2'b11) begin
                grant_q <= rr_q ? 2'b10 : 2'b01;
                rr_q    <= ~rr_q;
              end else if (req[0]) begin
                grant_q <= 2'b01;
                rr_q    <= 1'b1;
              end else if (req[1]) begin
                grant_q <= 2'b10;
                rr_q    <= 1'b0;
              end
            end else if ((grant_q & req) == 2'b00) begin
              grant_q <= 2'b00;
            end
          end
        end
        S_COMMIT: state_q <= S_ACTIVE;
        default:  state_q <= S_ACTIVE;
      endcase
    end
  end

  assign grant       = grant_q;
  assign mario_x     = mx_q;
  assign mario_y     = my_q;
  assign goomba_x    = gx_q;
  assign goomba_y    = gy_q;
  assign background  = live_tiles_q;
  assign frame_count = frame_count_q;
  assign commit      = commit_q;
  assign overrun     = overrun_q;
  assign bad_addr    = bad_addr_q;
  assign fsm_state   = state_q;

endmodule

// File: tb/tb_vga_frame_update_scheduler.sv
// Directed bench for vga_frame_update_scheduler with a 4-cycle update window;
// expected values are hand-derived and tracked in exp_* variables.
module tb_vga_frame_update_scheduler;

  localparam int ROWS = 12;
  localparam int COLS = 17;
  localparam int WC   = 4;

  logic                            vga_clock = 1'b0;
  logic                            reset;
  logic                            vsync;
  logic [1:0]                      req;
  logic [1:0]                      grant;
  logic                            tile_we;
  logic [3:0]                      tile_row;
  logic [4:0]                      tile_col;
  logic [7:0]                      tile_data;
  logic                            pos_we;
  logic                            pos_sel;
  logic signed [31:0]              pos_x, pos_y;
  logic signed [31:0]              mario_x, mario_y, goomba_x, goomba_y;
  logic [ROWS-1:0][COLS-1:0][7:0]  background;
  logic [15:0]                     frame_count;
  logic                            commit, overrun, bad_addr;
  logic [1:0]                      fsm_state;

  logic [ROWS-1:0][COLS-1:0][7:0]  exp_bg;
  int                              n_asserts = 0;
  int                              n_fails   = 0;
  int                              lat;

  vga_frame_update_scheduler #(.WINDOW_CYCLES(WC)) dut (
    .vga_clock   (vga_clock),
    .reset       (reset),
    .vsync       (vsync),
    .req         (req),
    .grant       (grant),
    .tile_we     (tile_we),
    .tile_row    (tile_row),
    .tile_col    (tile_col),
    .tile_data   (tile_data),
    .pos_we      (pos_we),
    .pos_sel     (pos_sel),
    .pos_x       (pos_x),
    .pos_y       (pos_y),
    .mario_x     (mario_x),
    .mario_y     (mario_y),
    .goomba_x    (goomba_x),
    .goomba_y    (goomba_y),
    .background  (background),
    .frame_count (frame_count),
    .commit      (commit),
    .overrun     (overrun),
    .bad_addr    (bad_addr),
    .fsm_state   (fsm_state)
  );

  // Clock / reset
  always #5 vga_clock = ~vga_clock;

  task automatic tick();
    @(posedge vga_clock);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Drivers
  task automatic open_window();
    vsync = 1'b0;
    tick();
    vsync = 1'b1;
    tick();
  endtask

  task automatic sky_model();
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        exp_bg[r][c] = 8'd1;
  endtask

  // Scoreboard
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, $signed(obs), $signed(exp));
    end
  endtask

  task automatic chk_bg(input string tag);
    int br, bc;
    br = -1;
    bc = -1;
    n_asserts++;
    assert (background === exp_bg) else begin
      n_fails++;
      for (int r = 0; r < ROWS; r++)
        for (int c = 0; c < COLS; c++)
          if (br < 0 && background[r][c] !== exp_bg[r][c]) begin
            br = r;
            bc = c;
          end
      if (br < 0) begin
        br = 0;
        bc = 0;
      end
      $error("FAIL %s: cell[%0d][%0d] observed %0d expected %0d", tag, br, bc,
             background[br][bc], exp_bg[br][bc]);
    end
  endtask

  initial begin
    reset = 1'b0; vsync = 1'b1; req = 2'b00;
    tile_we = 1'b0; tile_row = '0; tile_col = '0; tile_data = '0;
    pos_we = 1'b0; pos_sel = 1'b0; pos_x = '0; pos_y = '0;
    sky_model();
    ticks(3);

    // Reset state
    chk("rst_state", 32'(fsm_state), 32'd0);
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_fc", 32'(frame_count), 32'd0);
    chk("rst_commit", 32'(commit), 32'd0);
    chk("rst_overrun", 32'(overrun), 32'd0);
    chk("rst_bad", 32'(bad_addr), 32'd0);
    chk("rst_mx", mario_x, 32'd0);
    chk_bg("rst_bg");
    reset = 1'b1;
    ticks(4);

    // Commit latency from the registered vsync edge, no requests
    vsync = 1'b0;
    tick();
    vsync = 1'b1;
    lat = 0;
    for (int n = 1; n <= 20; n++) begin
      tick();
      if (commit === 1'b1) begin
        lat = n;
        break;
      end
    end
    chk("commit_latency", 32'(lat), 32'(WC + 1));
    chk("t1_fc", 32'(frame_count), 32'd1);
    chk_bg("t1_bg");
    tick();
    chk("t1_commit_pulse", 32'(commit), 32'd0);
    ticks(3);
    chk("t1_fc_idle", 32'(frame_count), 32'd1);

    // Round-robin: both request, drop winner, loser granted after a gap
    open_window();
    req = 2'b11;
    tick();
    chk("t3a_grant01", 32'(grant), 32'd1);
    req = 2'b10;
    tick();
    chk("t3a_grant00", 32'(grant), 32'd0);
    tick();
    chk("t3a_grant10", 32'(grant), 32'd2);
    req = 2'b00;
    tick();
    chk("t3a_close_grant", 32'(grant), 32'd0);
    chk("t3a_commit", 32'(commit), 32'd1);
    chk("t3a_overrun", 32'(overrun), 32'd0);
    chk("t3a_fc", 32'(frame_count), 32'd2);
    tick();
    // Pointer returned to writer 0 after writer 1 was served
    open_window();
    req = 2'b11;
    tick();
    chk("t3b_grant01", 32'(grant), 32'd1);
    req = 2'b00;
    ticks(4);
    // Writer 0 was served last, so writer 1 now wins
    open_window();
    req = 2'b11;
    tick();
    chk("t3c_grant10", 32'(grant), 32'd2);
    req = 2'b00;
    ticks(4);
    chk("t3c_fc", 32'(frame_count), 32'd4);

    // Tile write visible only after commit
    open_window();
    req = 2'b01;
    tick();
    chk("t2_grant", 32'(grant), 32'd1);
    tile_we = 1'b1; tile_row = 4'd3; tile_col = 5'd5; tile_data = 8'd2;
    tick();
    tile_we = 1'b0; req = 2'b00;
    chk_bg("t2_bg_before");
    tick();
    chk_bg("t2_bg_before2");
    tick();
    exp_bg[3][5] = 8'd2;
    chk_bg("t2_bg_after");
    chk("t2_commit", 32'(commit), 32'd1);
    tick();

    // Position writes: ignored without grant, applied with grant, live at commit
    req = 2'b01;
    pos_we = 1'b1; pos_sel = 1'b0; pos_x = 32'sd55; pos_y = 32'sd66;
    tick();
    open_window();
    chk("t4_no_grant", 32'(grant), 32'd0);
    tick();
    chk("t4_grant", 32'(grant), 32'd1);
    pos_x = 32'sd100; pos_y = -32'sd20;
    tile_we = 1'b1; tile_row = 4'd0; tile_col = 5'd0; tile_data = 8'd7;
    tick();
    tile_we = 1'b0;
    pos_sel = 1'b1; pos_x = -32'sd5; pos_y = 32'sd9;
    req = 2'b00;
    chk("t4_mx_hidden", mario_x, 32'd0);
    tick();
    pos_we = 1'b0;
    chk("t4_my_hidden", mario_y, 32'd0);
    tick();
    exp_bg[0][0] = 8'd7;
    chk("t4_mx", mario_x, 32'd100);
    chk("t4_my", mario_y, -32'sd20);
    chk("t4_gx", goomba_x, -32'sd5);
    chk("t4_gy", goomba_y, 32'd9);
    chk_bg("t4_bg");
    chk("t4_fc", 32'(frame_count), 32'd6);
    tick();

    // Bad address, overrun, vsync edge inside window ignored
    open_window();
    req = 2'b10;
    tick();
    chk("t5_grant", 32'(grant), 32'd2);
    tile_we = 1'b1; tile_row = 4'd12; tile_col = 5'd0; tile_data = 8'd9;
    vsync = 1'b0;
    tick();
    tile_we = 1'b0;
    vsync = 1'b1;
    chk("t5_bad", 32'(bad_addr), 32'd1);
    tick();
    chk("t5_grant_held", 32'(grant), 32'd2);
    tick();
    chk("t5_close_grant", 32'(grant), 32'd0);
    chk("t5_overrun", 32'(overrun), 32'd1);
    chk("t5_commit", 32'(commit), 32'd1);
    chk_bg("t5_bg");
    tick();
    chk("t5_active_grant", 32'(grant), 32'd0);
    req = 2'b00;
    ticks(4);
    chk("t5_fc_no_restart", 32'(frame_count), 32'd7);
    chk("t5_bad_sticky", 32'(bad_addr), 32'd1);
    chk("t5_overrun_sticky", 32'(overrun), 32'd1);

    // Reset mid-window discards shadow writes
    open_window();
    req = 2'b01;
    tick();
    tile_we = 1'b1; tile_row = 4'd1; tile_col = 5'd1; tile_data = 8'd5;
    pos_we = 1'b1; pos_sel = 1'b1; pos_x = 32'sd77; pos_y = 32'sd88;
    tick();
    tile_we = 1'b0; pos_we = 1'b0;
    reset = 1'b0;
    #1;
    sky_model();
    chk("t6_grant", 32'(grant), 32'd0);
    chk("t6_mx", mario_x, 32'd0);
    chk("t6_gx", goomba_x, 32'd0);
    chk("t6_fc", 32'(frame_count), 32'd0);
    chk("t6_overrun", 32'(overrun), 32'd0);
    chk("t6_bad", 32'(bad_addr), 32'd0);
    chk_bg("t6_bg");
    req = 2'b00;
    #2;
    reset = 1'b1;
    ticks(4);
    open_window();
    ticks(4);
    chk("t6_post_commit", 32'(commit), 32'd1);
    chk("t6_post_fc", 32'(frame_count), 32'd1);
    chk("t6_post_gx", goomba_x, 32'd0);
    chk_bg("t6_post_bg");
    tick();
    for (int f = 0; f < 3; f++) begin
      open_window();
      ticks(5);
    end
    chk("t6_fc_multi", 32'(frame_count), 32'd4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
